// File: rtl/button_pkg.sv
// Shared constants for the button conditioner: one-hot channel states, default timing, width helper.
// Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
package button_pkg;

  typedef enum logic [4:0] {
    ST_INI  = 5'b00001,
    ST_W84  = 5'b00010,
    ST_SCEN = 5'b00100,
    ST_CCR  = 5'b01000,
    ST_WFCR = 5'b10000
  } state_e;

  localparam int unsigned DEF_NUM_BTNS        = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Single button channel: 2-flop synchronizer, debounce FSM with registered level/pulse outputs.
// Define AUTO_REPEAT_EN to add held-button auto-repeat pulses.
module debounce_fsm
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic dpb,
  output logic scen
);

  localparam int unsigned CNT_W = bits_for(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s0_q, s1_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dpb_q, dpb_d;
  logic             scen_q, scen_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = bits_for(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             phase_q, phase_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      state_q <= ST_INI;
      cnt_q   <= '0;
      dpb_q   <= 1'b0;
      scen_q  <= 1'b0;
    end else begin
      s0_q    <= btn;
      s1_q    <= s0_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dpb_q   <= dpb_d;
      scen_q  <= scen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INI: begin
        if (s1_q) begin
          state_d = ST_W84;
          cnt_d   = '0;
        end
      end
      ST_W84: begin
        if (!s1_q)                  state_d = ST_INI;
        else if (cnt_q == CNT_LAST) state_d = ST_SCEN;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_SCEN: state_d = ST_CCR;
      ST_CCR: begin
        if (!s1_q) begin
          state_d = ST_WFCR;
          cnt_d   = '0;
        end
      end
      ST_WFCR: begin
        // A high sample here is release bounce, so the press is still held.
        if (s1_q)                   state_d = ST_CCR;
        else if (cnt_q == CNT_LAST) state_d = ST_INI;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = ST_INI;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    dpb_d  = (state_d == ST_SCEN) || (state_d == ST_CCR) || (state_d == ST_WFCR);
    scen_d = (state_d == ST_SCEN);
`ifdef AUTO_REPEAT_EN
    rpt_d   = rpt_q;
    phase_d = phase_q;
    rpt_inc = rpt_q + RPT_W'(1);
    if (state_d == ST_SCEN) begin
      rpt_d   = '0;
      phase_d = 1'b0;
    end else if (state_d == ST_CCR) begin
      // First target is the initial delay, then the period; counter restarts at each pulse.
      if (rpt_inc == (phase_q ? RPT_NEXT : RPT_FIRST)) begin
        scen_d  = 1'b1;
        rpt_d   = '0;
        phase_d = 1'b1;
      end else begin
        rpt_d = rpt_inc;
      end
    end
`endif
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      phase_q <= phase_d;
    end
  end
`endif

  assign dpb  = dpb_q;
  assign scen = scen_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTNS raw button pins into levels (DPBs) and press pulses (SCENs).
// Define AUTO_REPEAT_EN to add held-button auto-repeat pulses on SCENs.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = DEF_NUM_BTNS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn,
  output logic [NUM_BTNS-1:0] DPBs,
  output logic [NUM_BTNS-1:0] SCENs
);

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
    debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[gi]),
      .dpb  (DPBs[gi]),
      .scen (SCENs[gi])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
// Edge numbering: edge 0 is the first rising edge that samples the new btn value.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] DPBs;
  logic [3:0] SCENs;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTNS       (4),
    .DEBOUNCE_CYCLES(8)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (6)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .DPBs (DPBs),
    .SCENs(SCENs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int e, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  // Pulse expected at press edge p; with auto-repeat also at p+20+6k while still held (before r).
  function automatic logic exp_scen(input int e, input int p, input int r);
    if (e == p) return 1'b1;
`ifdef AUTO_REPEAT_EN
    if (e >= p + 20 && e < r && ((e - p - 20) % 6) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic do_reset();
    btn   = 4'b0000;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    btn   = 4'b0000;
    reset = 1'b1;
    do_reset();
    check("reset_dpb", 0, DPBs, 4'b0000);
    check("reset_scen", 0, SCENs, 4'b0000);

    // Clean press on btn[0], release sampled at edge 40.
    btn = 4'b0001;
    for (int e = 0; e <= 55; e++) begin
      tick();
      if (e == 39) btn = 4'b0000;
      check("t1_scen", e, SCENs, {3'b000, exp_scen(e, 10, 42)});
      check("t1_dpb", e, DPBs, {3'b000, (e >= 10 && e < 50)});
    end

    // Bouncy press on btn[1]: 1,0,1,0 for 3 clocks each, then held from edge 12.
    do_reset();
    btn = 4'b0010;
    for (int e = 0; e <= 30; e++) begin
      tick();
      btn[1] = ((e + 1) >= 12) || ((((e + 1) / 3) % 2) == 0);
      check("t2_scen", e, SCENs, {2'b00, exp_scen(e, 22, 1000), 1'b0});
      check("t2_dpb", e, DPBs, {2'b00, (e >= 22), 1'b0});
    end

    // Glitch on btn[2] lasting 5 clocks.
    do_reset();
    btn = 4'b0100;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 4) btn = 4'b0000;
      check("t3_scen", e, SCENs, 4'b0000);
      check("t3_dpb", e, DPBs, 4'b0000);
    end

    // All four buttons pressed together.
    do_reset();
    btn = 4'b1111;
    for (int e = 0; e <= 14; e++) begin
      tick();
      check("t4_scen", e, SCENs, (e == 10) ? 4'b1111 : 4'b0000);
      check("t4_dpb", e, DPBs, (e >= 10) ? 4'b1111 : 4'b0000);
    end

    // Reset sampled at edge 6 of a press; first post-reset sample at edge 7.
    do_reset();
    btn = 4'b0001;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 5) reset = 1'b1;
      if (e == 6) reset = 1'b0;
      check("t5_scen", e, SCENs, {3'b000, (e == 17)});
      check("t5_dpb", e, DPBs, {3'b000, (e >= 17)});
    end

    // Long hold on btn[3] for 60 clocks (auto-repeat window).
    do_reset();
    btn = 4'b1000;
    for (int e = 0; e <= 75; e++) begin
      tick();
      if (e == 59) btn = 4'b0000;
      check("t6_scen", e, SCENs, {exp_scen(e, 10, 62), 3'b000});
      check("t6_dpb", e, DPBs, {(e >= 10 && e < 70), 3'b000});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
